// File: rtl/bram_pkg.sv
// Shared types and constants for the BRAM front-end arbiter and its response FIFO.
package bram_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 8;
    localparam int unsigned RSP_FIFO_DEPTH     = 2;
    localparam int unsigned RSP_CNT_W          = $clog2(RSP_FIFO_DEPTH + 1);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_WR,
        GRANT_RD
    } grant_t;

    // Round-robin partner of the previous grant.
    function automatic grant_t other_grant(input grant_t last);
        return (last == GRANT_WR) ? GRANT_RD : GRANT_WR;
    endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Two-entry response FIFO; head data is held in a register so it stays stable under back-pressure.
module bram_rsp_fifo
    import bram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [RSP_CNT_W-1:0]  count,
    output logic                  not_empty,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem [RSP_FIFO_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  do_pop;
    logic [RSP_CNT_W-1:0]  count_next;

    assign do_pop = pop & not_empty;
    assign head   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, do_pop})
            2'b10:   count_next = count + RSP_CNT_W'(1);
            2'b01:   count_next = count - RSP_CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Storage carries no reset; validity is tracked by count/not_empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= '0;
            not_empty <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count     <= count_next;
            not_empty <= (count_next != '0);
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Sole driver of a single-port BRAM: optional post-reset init sweep, then round-robin
// arbitration of a write channel and a credit-limited read channel with buffered responses.
module bram_port_arbiter
    import bram_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int unsigned           ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
    parameter bit                    INIT_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_di,
    input  logic [DATA_WIDTH-1:0] bram_dout
);

    localparam int unsigned           OCC_W       = RSP_CNT_W + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;
    localparam state_t                RESET_STATE = INIT_ON_RESET ? INIT : RUN;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  init_cnt;
    logic                   inflight;
    grant_t                 last_grant;
    grant_t                 grant;
    logic [RSP_CNT_W-1:0]   fifo_count;
    logic [OCC_W-1:0]       occupancy;
    logic                   credit;
    logic                   pop;

    // Credit counts FIFO entries plus the read already in the BRAM pipe, net of this cycle's pop.
    always_comb begin
        pop       = rsp_valid & rsp_ready;
        occupancy = OCC_W'(fifo_count) + OCC_W'(inflight) - OCC_W'(pop);
        credit    = (occupancy < OCC_W'(RSP_FIFO_DEPTH));
        grant     = GRANT_NONE;
        if (!rst && state == RUN) begin
            if (wr_valid && rd_valid && credit) begin
                grant = other_grant(last_grant);
            end else if (wr_valid) begin
                grant = GRANT_WR;
            end else if (rd_valid && credit) begin
                grant = GRANT_RD;
            end
        end
    end

    always_comb begin
        wr_ready  = 1'b0;
        rd_ready  = 1'b0;
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = wr_addr;
        bram_di   = wr_data;
        if (!rst && state == INIT) begin
            bram_en   = 1'b1;
            bram_we   = 1'b1;
            bram_addr = init_cnt;
            bram_di   = INIT_VALUE;
        end else begin
            case (grant)
                GRANT_WR: begin
                    wr_ready = 1'b1;
                    bram_en  = 1'b1;
                    bram_we  = 1'b1;
                end
                GRANT_RD: begin
                    rd_ready  = 1'b1;
                    bram_en   = 1'b1;
                    bram_addr = rd_addr;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RESET_STATE;
            init_cnt   <= '0;
            init_done  <= 1'(!INIT_ON_RESET);
            inflight   <= 1'b0;
            last_grant <= GRANT_RD;
        end else begin
            inflight <= (grant == GRANT_RD);
            if (grant != GRANT_NONE) begin
                last_grant <= grant;
            end
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + ADDR_WIDTH'(1);
                    if (init_cnt == LAST_ADDR) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // BRAM output is only meaningful the cycle after a read-enabled edge.
    bram_rsp_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_data(bram_dout),
        .pop      (pop),
        .count    (fifo_count),
        .not_empty(rsp_valid),
        .head     (rsp_data)
    );

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench: a 16-deep instance with init sweep and an 8-bit-address instance without,
// each driving a behavioural write-first BRAM.
module tb_bram_port_arbiter;

    logic clk;

    logic        s_rst, s_wr_valid, s_wr_ready, s_rd_valid, s_rd_ready;
    logic [3:0]  s_wr_addr, s_rd_addr, s_bram_addr;
    logic [15:0] s_wr_data, s_rsp_data, s_bram_di, s_bram_dout;
    logic        s_rsp_valid, s_rsp_ready, s_init_done, s_bram_en, s_bram_we;

    logic        m_rst, m_wr_valid, m_wr_ready, m_rd_valid, m_rd_ready;
    logic [7:0]  m_wr_addr, m_rd_addr, m_bram_addr;
    logic [15:0] m_wr_data, m_rsp_data, m_bram_di, m_bram_dout;
    logic        m_rsp_valid, m_rsp_ready, m_init_done, m_bram_en, m_bram_we;

    logic [15:0] mem_s [16];
    logic [15:0] mem_m [256];

    int n_checks = 0;
    int n_errors = 0;

    bram_port_arbiter #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .INIT_VALUE(16'hA5A5), .INIT_ON_RESET(1'b1)
    ) dut_s (
        .clk(clk), .rst(s_rst),
        .wr_valid(s_wr_valid), .wr_ready(s_wr_ready), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .rd_valid(s_rd_valid), .rd_ready(s_rd_ready), .rd_addr(s_rd_addr),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data),
        .init_done(s_init_done),
        .bram_en(s_bram_en), .bram_we(s_bram_we), .bram_addr(s_bram_addr),
        .bram_di(s_bram_di), .bram_dout(s_bram_dout)
    );

    bram_port_arbiter #(
        .DATA_WIDTH(16), .ADDR_WIDTH(8), .INIT_VALUE(16'h0000), .INIT_ON_RESET(1'b0)
    ) dut_m (
        .clk(clk), .rst(m_rst),
        .wr_valid(m_wr_valid), .wr_ready(m_wr_ready), .wr_addr(m_wr_addr), .wr_data(m_wr_data),
        .rd_valid(m_rd_valid), .rd_ready(m_rd_ready), .rd_addr(m_rd_addr),
        .rsp_valid(m_rsp_valid), .rsp_ready(m_rsp_ready), .rsp_data(m_rsp_data),
        .init_done(m_init_done),
        .bram_en(m_bram_en), .bram_we(m_bram_we), .bram_addr(m_bram_addr),
        .bram_di(m_bram_di), .bram_dout(m_bram_dout)
    );

    // Write-first single-port BRAM models.
    always @(posedge clk) begin
        if (s_bram_en) begin
            if (s_bram_we) begin
                mem_s[s_bram_addr] <= s_bram_di;
                s_bram_dout        <= s_bram_di;
            end else begin
                s_bram_dout <= mem_s[s_bram_addr];
            end
        end
        if (m_bram_en) begin
            if (m_bram_we) begin
                mem_m[m_bram_addr] <= m_bram_di;
                m_bram_dout        <= m_bram_di;
            end else begin
                m_bram_dout <= mem_m[m_bram_addr];
            end
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sixteen sweep cycles: write of INIT_VALUE to address i, no handshakes, no response.
    task automatic s_sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("%s_%0d", tag, i),
                  32'({s_bram_en, s_bram_we, s_wr_ready, s_rd_ready, s_init_done, s_rsp_valid,
                       s_bram_addr, s_bram_di}),
                  32'({6'b110000, 4'(i), 16'hA5A5}));
            @(posedge clk); #1;
        end
    endtask

    task automatic s_read(input string tag, input logic [3:0] addr);
        s_rd_valid = 1'b1;
        s_rd_addr  = addr;
        @(negedge clk);
        check({tag, "_hs"}, 32'({s_rd_ready, s_bram_en, s_bram_we, s_bram_addr}),
              32'({3'b110, addr}));
        @(posedge clk); #1;
        s_rd_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat"}, 32'(s_rsp_valid), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_data"}, 32'({s_rsp_valid, s_rsp_data}), 32'({1'b1, 16'hA5A5}));
        @(posedge clk); #1;
    endtask

    // One cycle on the main instance: drive, then check grant, BRAM port and response.
    task automatic m_cycle(input string tag,
                           input logic wv, input logic [7:0] wa, input logic [15:0] wd,
                           input logic rv, input logic [7:0] ra, input logic rr,
                           input logic exp_w, input logic exp_r,
                           input logic exp_rv, input logic [15:0] exp_data);
        logic [7:0]  a_e;
        logic [15:0] d_e;
        m_wr_valid  = wv;
        m_wr_addr   = wa;
        m_wr_data   = wd;
        m_rd_valid  = rv;
        m_rd_addr   = ra;
        m_rsp_ready = rr;
        a_e = exp_w ? wa : (exp_r ? ra : 8'h00);
        d_e = exp_w ? wd : 16'h0000;
        @(negedge clk);
        check({tag, "_rdy"}, 32'({m_wr_ready, m_rd_ready}), 32'({exp_w, exp_r}));
        check({tag, "_bram"},
              32'({m_bram_en, m_bram_we, m_bram_en ? m_bram_addr : 8'h00,
                   m_bram_we ? m_bram_di : 16'h0000}),
              32'({exp_w | exp_r, exp_w, a_e, d_e}));
        check({tag, "_rsp"}, 32'({m_rsp_valid, m_rsp_valid ? m_rsp_data : 16'h0000}),
              32'({exp_rv, exp_rv ? exp_data : 16'h0000}));
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_s[i] = 16'hDEAD;
        for (int i = 0; i < 256; i++) mem_m[i] = 16'h0000;
        s_rst = 1'b1; s_wr_valid = 1'b1; s_wr_addr = 4'h3; s_wr_data = 16'h5555;
        s_rd_valid = 1'b1; s_rd_addr = 4'h2; s_rsp_ready = 1'b0;
        m_rst = 1'b1; m_wr_valid = 1'b1; m_wr_addr = 8'h00; m_wr_data = 16'h0000;
        m_rd_valid = 1'b1; m_rd_addr = 8'h00; m_rsp_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Small instance: reset state, sweep, init_done on cycle 17, reads of swept data.
        @(negedge clk);
        check("s_reset", 32'({s_bram_en, s_bram_we, s_wr_ready, s_rd_ready, s_init_done, s_rsp_valid}),
              32'(0));
        @(posedge clk); #1;
        s_rst = 1'b0;
        s_sweep("sweep1");
        s_wr_valid = 1'b0;
        s_rd_valid = 1'b0;
        @(negedge clk);
        check("s_init_done", 32'({s_init_done, s_bram_en}), 32'({1'b1, 1'b0}));
        @(posedge clk); #1;
        s_rsp_ready = 1'b1;
        s_read("s_rd3", 4'h3);
        s_read("s_rdF", 4'hF);

        // Reset with one read in flight and one FIFO entry pending.
        s_rsp_ready = 1'b0;
        s_rd_valid  = 1'b1;
        s_rd_addr   = 4'h5;
        @(negedge clk);
        check("s_mid_rd5", 32'(s_rd_ready), 32'(1));
        @(posedge clk); #1;
        s_rd_addr = 4'h6;
        @(negedge clk);
        check("s_mid_rd6", 32'(s_rd_ready), 32'(1));
        @(posedge clk); #1;
        s_rd_valid = 1'b0;
        @(negedge clk);
        check("s_pre_rst", 32'({s_rsp_valid, s_rsp_data}), 32'({1'b1, 16'hA5A5}));
        #1 s_rst = 1'b1;
        #1 check("s_rst_async", 32'({s_rsp_valid, s_bram_en, s_rd_ready, s_init_done}), 32'(0));
        @(posedge clk); #1;
        s_rst = 1'b0;
        s_sweep("sweep2");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("s_no_stale_%0d", i), 32'({s_rsp_valid, s_init_done}), 32'({1'b0, 1'b1}));
            @(posedge clk); #1;
        end
        s_rsp_ready = 1'b1;
        s_read("s_rd5", 4'h5);

        // Main instance: no sweep, init_done already high in reset.
        @(negedge clk);
        check("m_reset", 32'({m_wr_ready, m_rd_ready, m_bram_en, m_bram_we, m_rsp_valid, m_init_done}),
              32'(6'b000001));
        @(posedge clk); #1;
        m_rst = 1'b0;

        // Both channels busy: W,R,W,R,W,R starting from last_grant=READ.
        m_cycle("alt0", 1, 8'h40, 16'h1111, 1, 8'h40, 1, 1, 0, 0, 16'h0000);
        m_cycle("alt1", 1, 8'h41, 16'h2222, 1, 8'h40, 1, 0, 1, 0, 16'h0000);
        m_cycle("alt2", 1, 8'h41, 16'h2222, 1, 8'h41, 1, 1, 0, 0, 16'h0000);
        m_cycle("alt3", 1, 8'h42, 16'h3333, 1, 8'h41, 1, 0, 1, 1, 16'h1111);
        m_cycle("alt4", 1, 8'h42, 16'h3333, 1, 8'h42, 1, 1, 0, 0, 16'h0000);
        m_cycle("alt5", 1, 8'h43, 16'h4444, 1, 8'h42, 1, 0, 1, 1, 16'h2222);
        m_cycle("alt6", 0, 8'h00, 16'h0000, 0, 8'h00, 1, 0, 0, 0, 16'h0000);
        m_cycle("alt7", 0, 8'h00, 16'h0000, 0, 8'h00, 1, 0, 0, 1, 16'h3333);
        m_cycle("alt8", 0, 8'h00, 16'h0000, 0, 8'h00, 1, 0, 0, 0, 16'h0000);

        m_cycle("pre1",  1, 8'h01, 16'h0001, 0, 8'h00, 1, 1, 0, 0, 16'h0000);
        m_cycle("pre2",  1, 8'h02, 16'h0002, 0, 8'h00, 1, 1, 0, 0, 16'h0000);
        m_cycle("pre3",  1, 8'h03, 16'h0003, 0, 8'h00, 1, 1, 0, 0, 16'h0000);
        m_cycle("pre4",  1, 8'h04, 16'h0004, 0, 8'h00, 1, 1, 0, 0, 16'h0000);
        m_cycle("pre20", 1, 8'h20, 16'h00FF, 0, 8'h00, 1, 1, 0, 0, 16'h0000);

        // Write then read of the same address on the next cycle.
        m_cycle("wr10", 1, 8'h10, 16'h1234, 0, 8'h00, 1, 1, 0, 0, 16'h0000);
        m_cycle("rd10", 0, 8'h00, 16'h0000, 1, 8'h10, 1, 0, 1, 0, 16'h0000);
        m_cycle("lat1", 0, 8'h00, 16'h0000, 0, 8'h00, 1, 0, 0, 0, 16'h0000);
        m_cycle("lat2", 0, 8'h00, 16'h0000, 0, 8'h00, 1, 0, 0, 1, 16'h1234);
        m_cycle("lat3", 0, 8'h00, 16'h0000, 0, 8'h00, 1, 0, 0, 0, 16'h0000);

        // Back-pressure: two reads accepted, head holds, then drain in order.
        m_cycle("bp0", 0, 8'h00, 16'h0000, 1, 8'h01, 0, 0, 1, 0, 16'h0000);
        m_cycle("bp1", 0, 8'h00, 16'h0000, 1, 8'h02, 0, 0, 1, 0, 16'h0000);
        m_cycle("bp2", 0, 8'h00, 16'h0000, 1, 8'h03, 0, 0, 0, 1, 16'h0001);
        m_cycle("bp3", 0, 8'h00, 16'h0000, 1, 8'h03, 0, 0, 0, 1, 16'h0001);
        m_cycle("bp4", 0, 8'h00, 16'h0000, 1, 8'h03, 0, 0, 0, 1, 16'h0001);
        m_cycle("bp5", 0, 8'h00, 16'h0000, 1, 8'h03, 1, 0, 1, 1, 16'h0001);
        m_cycle("bp6", 0, 8'h00, 16'h0000, 1, 8'h04, 1, 0, 1, 1, 16'h0002);
        m_cycle("bp7", 0, 8'h00, 16'h0000, 0, 8'h00, 1, 0, 0, 1, 16'h0003);
        m_cycle("bp8", 0, 8'h00, 16'h0000, 0, 8'h00, 1, 0, 0, 1, 16'h0004);
        m_cycle("bp9", 0, 8'h00, 16'h0000, 0, 8'h00, 1, 0, 0, 0, 16'h0000);

        // Read then write of the same address: old data returned, new data afterwards.
        m_cycle("rw0", 0, 8'h00, 16'h0000, 1, 8'h20, 1, 0, 1, 0, 16'h0000);
        m_cycle("rw1", 1, 8'h20, 16'hBEEF, 0, 8'h00, 1, 1, 0, 0, 16'h0000);
        m_cycle("rw2", 0, 8'h00, 16'h0000, 0, 8'h00, 1, 0, 0, 1, 16'h00FF);
        m_cycle("rw3", 0, 8'h00, 16'h0000, 1, 8'h20, 1, 0, 1, 0, 16'h0000);
        m_cycle("rw4", 0, 8'h00, 16'h0000, 0, 8'h00, 1, 0, 0, 0, 16'h0000);
        m_cycle("rw5", 0, 8'h00, 16'h0000, 0, 8'h00, 1, 0, 0, 1, 16'hBEEF);
        m_cycle("rw6", 0, 8'h00, 16'h0000, 0, 8'h00, 1, 0, 0, 0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
